// File: rtl/posture_uart_tx.sv
// Posture sensor reporter: debounces five raw inputs and sends {3'b101, sensors} as a UART 8N1 byte on change.
// Optional periodic resend of the current vector is built when POSTURE_HEARTBEAT_EN is defined.
module posture_uart_tx #(
    parameter int CLK_HZ           = 12000000,
    parameter int BAUD             = 115200,
    parameter int DEBOUNCE_CYCLES  = 120000,
    parameter int HEARTBEAT_CYCLES = 12000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       drops_in,
    input  logic       hoods_in,
    input  logic       tops_in,
    input  logic       bar_in,
    input  logic       seat_in,
    output logic       tx,
    output logic       busy,
    output logic       frame_sent,
    output logic [4:0] sensors
);

    localparam int BIT_CYCLES = CLK_HZ / BAUD;
    localparam int BW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef logic [BW-1:0] bit_cnt_t;
    typedef logic [DW-1:0] db_cnt_t;

    localparam bit_cnt_t BIT_LAST = bit_cnt_t'(BIT_CYCLES - 1);
    localparam bit_cnt_t BIT_PRE  = bit_cnt_t'(BIT_CYCLES - 2);
    localparam bit_cnt_t BIT_ONE  = bit_cnt_t'(1);
    localparam db_cnt_t  DB_LAST  = db_cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam db_cnt_t  DB_ONE   = db_cnt_t'(1);

    // frame_sent is raised one clock before STOP ends, so at least two clocks per bit are needed
    if (BIT_CYCLES < 2 || DEBOUNCE_CYCLES < 1 || HEARTBEAT_CYCLES < 1) begin : g_param_check
        $error("posture_uart_tx: invalid parameter set");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [4:0]          raw_s;
    logic [4:0]          sync1_q, sync2_q;
    logic [4:0]          sensors_q, sensors_d;
    logic [4:0][DW-1:0]  db_cnt_q, db_cnt_d;
    logic [4:0]          last_sent_q, last_sent_d;
    logic [7:0]          byte_q, byte_d;
    state_t              state_q, state_d;
    bit_cnt_t            bit_cnt_q, bit_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [2:0]          nxt_idx_s;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                frame_sent_q, frame_sent_d;
    logic                send_now_s;

    assign raw_s      = {seat_in, bar_in, tops_in, hoods_in, drops_in};
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_sent = frame_sent_q;
    assign sensors    = sensors_q;
    assign nxt_idx_s  = bit_idx_q + 3'd1;

    // Per-bit debounce: a bit flips only after DEBOUNCE_CYCLES consecutive disagreeing clocks
    always_comb begin
        sensors_d = sensors_q;
        db_cnt_d  = db_cnt_q;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] != sensors_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    sensors_d[i] = sync2_q[i];
                    db_cnt_d[i]  = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

`ifdef POSTURE_HEARTBEAT_EN
    localparam int HW = $clog2(HEARTBEAT_CYCLES + 1);
    typedef logic [HW-1:0] hb_cnt_t;
    localparam hb_cnt_t HB_LAST = hb_cnt_t'(HEARTBEAT_CYCLES - 1);
    localparam hb_cnt_t HB_ONE  = hb_cnt_t'(1);

    hb_cnt_t hb_cnt_q, hb_cnt_d;
    logic    hb_due_s;

    assign hb_due_s   = (state_q == IDLE) && (hb_cnt_q == HB_LAST);
    assign send_now_s = (sensors_q != last_sent_q) || hb_due_s;

    // Idle-time counter; a due heartbeat and a change in the same clock share one frame
    always_comb begin
        if (frame_sent_q || hb_due_s) begin
            hb_cnt_d = '0;
        end else if (state_q == IDLE) begin
            hb_cnt_d = hb_cnt_q + HB_ONE;
        end else begin
            hb_cnt_d = hb_cnt_q;
        end
    end

    // Heartbeat counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
        end
    end
`else
    assign send_now_s = (sensors_q != last_sent_q);
`endif

    // Transmit FSM next-state and registered line outputs
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        byte_d       = byte_q;
        last_sent_d  = last_sent_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        frame_sent_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (send_now_s) begin
                    state_d     = START;
                    byte_d      = {3'b101, sensors_q};
                    last_sent_d = sensors_q;
                    bit_cnt_d   = '0;
                    tx_d        = 1'b0;
                    busy_d      = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            START: begin
                if (bit_cnt_q == BIT_LAST) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = byte_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                end
            end
            DATA: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = nxt_idx_s;
                        tx_d      = byte_q[nxt_idx_s];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                end
            end
            STOP: begin
                if (bit_cnt_q == BIT_LAST) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    // pulse lands on the final stop-bit clock, closing the 10-bit window
                    if (bit_cnt_q == BIT_PRE) begin
                        frame_sent_d = 1'b1;
                    end else begin
                        frame_sent_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    // All state registers; reset forces the line idle-high asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 5'b00000;
            sync2_q      <= 5'b00000;
            sensors_q    <= 5'b00000;
            db_cnt_q     <= '0;
            last_sent_q  <= 5'b00000;
            byte_q       <= 8'h00;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            bit_idx_q    <= 3'd0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_sent_q <= 1'b0;
        end else begin
            sync1_q      <= raw_s;
            sync2_q      <= sync1_q;
            sensors_q    <= sensors_d;
            db_cnt_q     <= db_cnt_d;
            last_sent_q  <= last_sent_d;
            byte_q       <= byte_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_sent_q <= frame_sent_d;
        end
    end

endmodule

// File: doc/posture_uart_tx.md
POSTURE_UART_TX -- requirements
Module: posture_uart_tx

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter CLK_HZ, default 12000000, giving the clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, giving the serial bit rate.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 120000, giving the stable-input clocks required before a sensor change is accepted.
REQ-004 The block SHALL have parameter HEARTBEAT_CYCLES, default 12000000, giving the idle clocks between periodic resends; it is used only with the heartbeat option.

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, reset; reset is asynchronous and active-low.
REQ-007 The block SHALL have ports drops_in, hoods_in, tops_in, bar_in and seat_in, each input, 1, an asynchronous raw sensor/button level.
REQ-008 The block SHALL have port tx, output, 1, the UART 8N1 serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1, high while a frame is on tx.
REQ-010 The block SHALL have port frame_sent, output, 1, a one-clock pulse at the end of each stop bit.
REQ-011 The block SHALL have port sensors, output, 5, the debounced vector {seat,bar,tops,hoods,drops}.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each synchronized input SHALL update its sensors bit only after it has differed from that bit for DEBOUNCE_CYCLES consecutive clocks; any intermediate return to the old value SHALL restart that bit's count.
REQ-014 The block SHALL keep last_sent (5 bits), the vector carried by the most recent frame.
REQ-015 The FSM SHALL have exactly the states IDLE, START, DATA and STOP.
REQ-016 In IDLE, when sensors != last_sent, the FSM SHALL latch byte = {3'b101, sensors}, copy sensors into last_sent, and enter START on the next clock.
REQ-017 BIT_CYCLES SHALL equal CLK_HZ/BAUD (integer division), and each state SHALL hold one bit for BIT_CYCLES clocks.
REQ-018 In START, tx SHALL be 0.
REQ-019 In DATA, tx SHALL carry byte bits 0..7, LSB first, using a 3-bit index.
REQ-020 In STOP, tx SHALL be 1.
REQ-021 When STOP completes, the FSM SHALL return to IDLE with frame_sent=1 for that one clock.
REQ-022 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-023 The latched byte SHALL NOT change while busy=1.
REQ-024 Sensor changes during a frame SHALL coalesce: after the frame ends, IDLE compares the current sensors against last_sent, so only the latest value is sent and an A->B->A change within one frame sends nothing.
REQ-025 If a change is detected in the same clock that STOP completes, that clock SHALL go to IDLE, and the new frame SHALL start on the following clock; there SHALL be a minimum of one idle clock between frames.
REQ-026 Total frame time SHALL be exactly 10*BIT_CYCLES clocks, from the first START clock to the frame_sent clock inclusive.

Reset
REQ-027 While rst_n=0, the block SHALL force tx=1, busy=0, frame_sent=0, sensors=0, last_sent=0, the FSM to IDLE, all counters to 0 and the synchronizers to 0.
REQ-028 An rst_n assertion mid-frame SHALL abort the frame immediately, with tx going high asynchronously.
REQ-029 After reset release, no frame SHALL be sent until a debounced sensor differs from 0.

Configuration
REQ-030 The heartbeat feature SHALL be controlled by macro POSTURE_HEARTBEAT_EN.
REQ-031 With POSTURE_HEARTBEAT_EN defined, a counter SHALL clear on every frame_sent and on reset, and count while IDLE.
REQ-032 With POSTURE_HEARTBEAT_EN defined, when that counter reaches HEARTBEAT_CYCLES-1, the block SHALL send {3'b101, sensors} even if unchanged.
REQ-033 If a change-triggered frame and a heartbeat frame fall due in the same clock, the block SHALL send one frame only.
REQ-034 Without POSTURE_HEARTBEAT_EN, the block SHALL contain no heartbeat logic, and frames SHALL occur only on change.

Verification
Bench parameters: CLK_HZ=1000000, BAUD=100000 (BIT_CYCLES=10), DEBOUNCE_CYCLES=4, HEARTBEAT_CYCLES=500.
REQ-035 Reset then idle 200 clocks -> tx=1 throughout, busy=0, no frame_sent.
REQ-036 drops_in raised and held -> sensors=5'b00001 after 2 sync + 4 debounce clocks; frame byte 8'hA1 on tx with the start bit on the next clock; frame_sent exactly 100 clocks after the start bit begins.
REQ-037 seat_in pulsed high for 3 clocks -> sensors unchanged and no frame.
REQ-038 hoods_in raised, then tops_in raised 30 clocks into that frame -> first frame 8'hA2, then one frame 8'hA6 starting 2 clocks after frame_sent.
REQ-039 rst_n dropped at clock 45 of a frame -> tx=1 asynchronously, busy=0; after release with all inputs low, no frame.
REQ-040 With POSTURE_HEARTBEAT_EN and bar_in held high -> an 8'hA8 frame repeats every 500 idle clocks after each frame_sent.
REQ-041 Without POSTURE_HEARTBEAT_EN and bar_in held high -> no repeat frame.
